i2s_adc_level_meter: RTL and testbench
======================================

// Module: i2s_adc_level_meter
// PURPOSE
//  Passive tap on the WM8731 ADC I2S lines (BCLK, ADCLRCK, ADCDAT) alongside audio_0.
//  Deserialises left/right samples, tracks peak magnitude with hold/decay, drives a
//  10-LED bar (6 dB/step), and feeds leds_0 via top-level muxing.
//  Codec is I2S master; this block only samples, never drives codec pins.
// PARAMETERS
//  SAMPLE_W       24    bits captured per channel, MSB first
//  LED_N          10    bar-graph LEDs
//  DECAY_FRAMES   4800  frames between decay steps (100 ms at 48 kHz)
// PORTS
//  clk           in   1         system clock, 50 MHz, >= 8x BCLK
//  reset_n       in   1         asynchronous active-low reset
//  bclk          in   1         codec bit clock, async to clk
//  adclrck       in   1         codec ADC LR clock, async; low = left
//  adcdat        in   1         codec ADC serial data, async
//  sample_valid  out  1         1-cycle pulse: sample_l/sample_r updated
//  sample_l      out  SAMPLE_W  last left sample, two's complement
//  sample_r      out  SAMPLE_W  last right sample, two's complement
//  peak_hold     out  SAMPLE_W-1  held peak magnitude
//  led           out  LED_N     bar graph, led[LED_N-1] = loudest
//  frame_err     out  1         1-cycle pulse: short channel slot discarded
// BEHAVIOUR
//  Reset: every output 0; bit counter 0; state WAIT_EDGE; decay counter 0.
//  Sync: bclk, adclrck, adcdat each pass a 2-FF synchroniser.
//  Bit sampling: a synced bclk rising edge (0->1) is one bit time.
//  Slot start: a synced adclrck change at a bclk rise starts a channel slot.
//    First bit: one bclk after the LRCK change (I2S delay).
//    Bits 1..SAMPLE_W shift in MSB first.
//    Extra bits in the slot are ignored; the counter saturates at SAMPLE_W+1.
//  FSM states:
//    WAIT_EDGE: the first LRCK change after reset goes to LEFT or RIGHT, by new level.
//    LEFT/RIGHT: on each LRCK change, close the slot and go to the other state.
//  Slot close:
//    Count >= SAMPLE_W: latch the word into the L or R shadow.
//    Count < SAMPLE_W: drop the word, pulse frame_err, invalidate the frame.
//  Frame complete: a right slot closes validly after a valid left slot.
//    sample_l/sample_r update together.
//    sample_valid pulses 2 clk after the closing LRCK edge is seen in the synced domain.
//  Magnitude:
//    |x| in SAMPLE_W-1 bits.
//    -2^(SAMPLE_W-1) saturates to 2^(SAMPLE_W-1)-1.
//    pk = max(|L|,|R|).
//  Peak hold (registered on sample_valid+1):
//    pk > peak_hold: peak_hold <= pk; decay counter resets to 0.
//    Otherwise the counter increments per frame.
//    At DECAY_FRAMES-1: peak_hold <= peak_hold - (peak_hold>>3); counter resets to 0.
//    Load and decay tick in the same frame: load wins.
//    peak_hold = 0 stays 0.
//  LED map (registered, 1 clk after peak_hold):
//    led[i] = (peak_hold >= 2^(SAMPLE_W-1-LED_N+i)).
//    Defaults: led[9] at 2^22 (-6 dBFS), led[0] at 2^13.
//  Async reset mid-slot: the partial word is lost; resume through WAIT_EDGE.
//  Latency: closing LRCK edge -> sample_valid = 4 clk (2 sync + edge + latch).
//    sample_valid -> led = 2 clk.
// STRUCTURE
//  audio_meter_pkg: SAMPLE_W/LED_N defaults, FSM state encoding, led threshold function.
//  Sub-module i2s_rx_deser: synchronisers, edge detect, FSM, shift register.
//    Outputs sample_l/r, sample_valid, frame_err.
//  Top: magnitude, peak hold/decay, LED encoder.
// TESTING
//  1 I2S model, BCLK 3.072 MHz, 48 kHz, 32-bit slots; L=24'h400000, R=24'h000100
//    -> sample_l/r match; peak_hold=22'h3FFFFF-sat? no: =0x400000 clipped to 23b
//    -> led=10'h3FF.
//  2 L=R=24'h800000 (most negative) -> peak_hold=23'h7FFFFF; led all lit.
//  3 One frame at 24'h010000, then silence, DECAY_FRAMES=4
//    -> peak_hold: 0x010000 then 0x00E000 after 4 frames, 0x00C400 after 8;
//    -> led drops per thresholds.
//  4 Left slot truncated to 16 BCLKs -> frame_err pulse once, no sample_valid that frame.
//    -> Next full frame updates normally.
//  5 reset_n asserted mid-right-slot for 3 clk -> all outputs 0 immediately.
//    -> First sample_valid only after the next complete L+R frame.
//  6 New peak on the same frame as a decay tick -> peak_hold = new pk, counter = 0.

Source files
------------

// File: rtl/audio_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_meter_pkg
// Description : Shared defaults, deserialiser state encoding and the LED
//               threshold helper for the I2S ADC level meter.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_meter_pkg;

    localparam int c_SAMPLE_W_DEF     = 24;
    localparam int c_LED_N_DEF        = 10;
    localparam int c_DECAY_FRAMES_DEF = 4800;

    localparam int                    c_STATE_W      = 2;
    localparam logic [c_STATE_W-1:0]  c_ST_WAIT_EDGE = 2'd0;
    localparam logic [c_STATE_W-1:0]  c_ST_LEFT      = 2'd1;
    localparam logic [c_STATE_W-1:0]  c_ST_RIGHT     = 2'd2;

    // LED idx lights when the held peak reaches 2^(returned bit position).
    function automatic int led_thresh_bit(input int sample_w, input int led_n, input int idx);
        return sample_w - 1 - led_n + idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : i2s_rx_deser
// Description : Passive I2S receiver: synchronises BCLK/LRCK/DATA into clk,
//               deserialises left/right words and flags short slots.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_deser
    import audio_meter_pkg::*;
#(
    parameter int SAMPLE_W = c_SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                bclk,
    input  logic                adclrck,
    input  logic                adcdat,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                frame_err
);

    localparam int                c_CNT_W    = $clog2(SAMPLE_W + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(SAMPLE_W);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(SAMPLE_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic                 r_bclk_m, r_bclk_s, r_bclk_p;
    logic                 r_lrck_m, r_lrck_s;
    logic                 r_dat_m,  r_dat_s;
    logic                 r_armed;
    logic                 r_lrck_last;
    logic [c_STATE_W-1:0] r_state;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [SAMPLE_W-1:0]  r_shift;
    logic [SAMPLE_W-1:0]  r_shadow_l;
    logic [SAMPLE_W-1:0]  r_shadow_r;
    logic                 r_l_ok;
    logic                 r_frame_done;
    logic                 r_slot_err;
    logic                 r_sample_valid;
    logic [SAMPLE_W-1:0]  r_sample_l;
    logic [SAMPLE_W-1:0]  r_sample_r;
    logic                 r_frame_err;

    logic w_bclk_rise;
    logic w_lrck_chg;
    logic w_slot_full;

    assign w_bclk_rise = r_bclk_s & ~r_bclk_p;
    // The first rise after reset only records the LRCK level, so a stale
    // reset value of the history bit can never fake a slot boundary.
    assign w_lrck_chg  = w_bclk_rise & r_armed & (r_lrck_s != r_lrck_last);
    assign w_slot_full = (r_bit_cnt >= c_CNT_FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_m <= 1'b0;
            r_bclk_s <= 1'b0;
            r_bclk_p <= 1'b0;
            r_lrck_m <= 1'b0;
            r_lrck_s <= 1'b0;
            r_dat_m  <= 1'b0;
            r_dat_s  <= 1'b0;
        end else begin
            r_bclk_m <= bclk;
            r_bclk_s <= r_bclk_m;
            r_bclk_p <= r_bclk_s;
            r_lrck_m <= adclrck;
            r_lrck_s <= r_lrck_m;
            r_dat_m  <= adcdat;
            r_dat_s  <= r_dat_m;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed      <= 1'b0;
            r_lrck_last  <= 1'b0;
            r_state      <= c_ST_WAIT_EDGE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_shadow_l   <= '0;
            r_shadow_r   <= '0;
            r_l_ok       <= 1'b0;
            r_frame_done <= 1'b0;
            r_slot_err   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_slot_err   <= 1'b0;
            if (w_bclk_rise) begin
                r_armed     <= 1'b1;
                r_lrck_last <= r_lrck_s;
            end
            if (w_lrck_chg) begin
                r_bit_cnt <= '0;
                case (r_state)
                    c_ST_LEFT: begin
                        if (w_slot_full) begin
                            r_shadow_l <= r_shift;
                            r_l_ok     <= 1'b1;
                        end else begin
                            r_slot_err <= 1'b1;
                            r_l_ok     <= 1'b0;
                        end
                    end
                    c_ST_RIGHT: begin
                        r_l_ok <= 1'b0;
                        if (w_slot_full) begin
                            r_shadow_r   <= r_shift;
                            r_frame_done <= r_l_ok;
                        end else begin
                            r_slot_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                r_state <= r_lrck_s ? c_ST_RIGHT : c_ST_LEFT;
            end else if (w_bclk_rise && (r_state != c_ST_WAIT_EDGE)) begin
                // The LRCK-change bit itself is the I2S delay bit and is skipped.
                if (r_bit_cnt < c_CNT_FULL) begin
                    r_shift <= {r_shift[SAMPLE_W-2:0], r_dat_s};
                end
                if (r_bit_cnt < c_CNT_SAT) begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample_valid <= 1'b0;
            r_sample_l     <= '0;
            r_sample_r     <= '0;
            r_frame_err    <= 1'b0;
        end else begin
            r_sample_valid <= r_frame_done;
            r_frame_err    <= r_slot_err;
            if (r_frame_done) begin
                r_sample_l <= r_shadow_l;
                r_sample_r <= r_shadow_r;
            end
        end
    end

    assign sample_valid = r_sample_valid;
    assign sample_l     = r_sample_l;
    assign sample_r     = r_sample_r;
    assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/i2s_adc_level_meter.sv
`default_nettype none
// ============================================================================
// Module      : i2s_adc_level_meter
// Description : I2S ADC tap with peak-hold/decay metering and a 6 dB/step
//               LED bar graph.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_adc_level_meter
    import audio_meter_pkg::*;
#(
    parameter int SAMPLE_W     = c_SAMPLE_W_DEF,
    parameter int LED_N        = c_LED_N_DEF,
    parameter int DECAY_FRAMES = c_DECAY_FRAMES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                bclk,
    input  logic                adclrck,
    input  logic                adcdat,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic [SAMPLE_W-2:0] peak_hold,
    output logic [LED_N-1:0]    led,
    output logic                frame_err
);

    localparam int                  c_DCNT_W     = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam logic [c_DCNT_W-1:0] c_DECAY_LAST = c_DCNT_W'(DECAY_FRAMES - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_ONE   = c_DCNT_W'(1);

    logic [SAMPLE_W-2:0] r_peak_hold;
    logic [c_DCNT_W-1:0] r_decay_cnt;
    logic [LED_N-1:0]    r_led;

    logic [SAMPLE_W-2:0] w_mag_l;
    logic [SAMPLE_W-2:0] w_mag_r;
    logic [SAMPLE_W-2:0] w_pk;
    logic [LED_N-1:0]    w_led;

    i2s_rx_deser #(
        .SAMPLE_W (SAMPLE_W)
    ) u_deser (
        .clk          (clk),
        .reset_n      (reset_n),
        .bclk         (bclk),
        .adclrck      (adclrck),
        .adcdat       (adcdat),
        .sample_valid (sample_valid),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .frame_err    (frame_err)
    );

    // The most negative code has no positive twin; clamp it to full scale.
    function automatic logic [SAMPLE_W-2:0] f_mag(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] neg;
        neg = -x;
        if (!x[SAMPLE_W-1]) begin
            return x[SAMPLE_W-2:0];
        end
        if (neg[SAMPLE_W-1]) begin
            return '1;
        end
        return neg[SAMPLE_W-2:0];
    endfunction

    assign w_mag_l = f_mag(sample_l);
    assign w_mag_r = f_mag(sample_r);
    assign w_pk    = (w_mag_l > w_mag_r) ? w_mag_l : w_mag_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_peak_hold <= '0;
            r_decay_cnt <= '0;
        end else if (sample_valid) begin
            if (w_pk > r_peak_hold) begin
                r_peak_hold <= w_pk;
                r_decay_cnt <= '0;
            end else if (r_decay_cnt == c_DECAY_LAST) begin
                r_peak_hold <= r_peak_hold - (r_peak_hold >> 3);
                r_decay_cnt <= '0;
            end else begin
                r_decay_cnt <= r_decay_cnt + c_DCNT_ONE;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LED_N; gi++) begin : g_led
            localparam int c_BIT = led_thresh_bit(SAMPLE_W, LED_N, gi);
            assign w_led[gi] = |r_peak_hold[SAMPLE_W-2:c_BIT];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_led;
        end
    end

    assign peak_hold = r_peak_hold;
    assign led       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_i2s_adc_level_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_adc_level_meter
// Description : Directed bench: I2S codec model feeding the level meter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_adc_level_meter;

    localparam int c_SW = 24;
    localparam int c_LN = 10;

    logic            clk;
    logic            reset_n;
    logic            bclk;
    logic            adclrck;
    logic            adcdat;
    logic            sample_valid;
    logic [c_SW-1:0] sample_l;
    logic [c_SW-1:0] sample_r;
    logic [c_SW-2:0] peak_hold;
    logic [c_LN-1:0] led;
    logic            frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int sv_cnt  = 0;
    int err_cnt = 0;
    int frame_cnt = 0;
    int in_right = 0;
    int drv_en = 0;
    int g_base = 0;

    logic [c_SW-1:0] cur_l = '0;
    logic [c_SW-1:0] cur_r = '0;
    int              l_len = 32;
    int              r_len = 32;

    i2s_adc_level_meter #(
        .SAMPLE_W     (c_SW),
        .LED_N        (c_LN),
        .DECAY_FRAMES (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bclk         (bclk),
        .adclrck      (adclrck),
        .adcdat       (adcdat),
        .sample_valid (sample_valid),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .peak_hold    (peak_hold),
        .led          (led),
        .frame_err    (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(negedge clk) begin
        if (sample_valid === 1'b1) sv_cnt++;
        if (frame_err === 1'b1)    err_cnt++;
    end

    // One I2S slot: LRCK and data change on BCLK fall, MSB one BCLK late.
    task automatic send_slot(input logic lv, input logic [c_SW-1:0] w, input int n);
        for (int b = 0; b < n; b++) begin
            bclk = 1'b0;
            if (b == 0) adclrck = lv;
            adcdat = (b >= 1 && b <= c_SW) ? w[c_SW-b] : 1'b0;
            #160;
            bclk = 1'b1;
            #160;
        end
    endtask

    initial begin : i2s_driver
        logic [c_SW-1:0] l, r;
        int ll, rl;
        bclk = 1'b0; adclrck = 1'b1; adcdat = 1'b0;
        wait (drv_en != 0);
        #7;
        forever begin
            l = cur_l; r = cur_r; ll = l_len; rl = r_len;
            frame_cnt++;
            in_right = 0;
            send_slot(1'b0, l, ll);
            in_right = 1;
            send_slot(1'b1, r, rl);
        end
    end

    task automatic wait_frame(input int target);
        int i;
        i = 0;
        while (frame_cnt < target && i < 8000) begin
            @(negedge clk);
            i++;
        end
        if (frame_cnt < target) begin
            n_tests++; n_fail++;
            $display("FAIL frame_timeout: frame %0d required %0d", frame_cnt, target);
        end
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", sample_valid); end
        n_tests++; if (sample_l !== '0) begin n_fail++; $display("FAIL rst_l: got %h exp 0", sample_l); end
        n_tests++; if (sample_r !== '0) begin n_fail++; $display("FAIL rst_r: got %h exp 0", sample_r); end
        n_tests++; if (peak_hold !== '0) begin n_fail++; $display("FAIL rst_peak: got %h exp 0", peak_hold); end
        n_tests++; if (led !== '0) begin n_fail++; $display("FAIL rst_led: got %h exp 0", led); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", frame_err); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        cur_l = 24'h400000; cur_r = 24'h000100;
        drv_en = 1;
        wait_frame(3);
        n_tests++; if (sample_l !== 24'h400000) begin n_fail++; $display("FAIL basic_l: got %h exp 400000", sample_l); end
        n_tests++; if (sample_r !== 24'h000100) begin n_fail++; $display("FAIL basic_r: got %h exp 000100", sample_r); end
        n_tests++; if (peak_hold !== 23'h400000) begin n_fail++; $display("FAIL basic_peak: got %h exp 400000", peak_hold); end
        n_tests++; if (led !== 10'h3FF) begin n_fail++; $display("FAIL basic_led: got %h exp 3ff", led); end
        n_tests++; if (sv_cnt !== 1) begin n_fail++; $display("FAIL basic_valid_cnt: got %0d exp 1", sv_cnt); end
        n_tests++; if (err_cnt !== 0) begin n_fail++; $display("FAIL basic_err_cnt: got %0d exp 0", err_cnt); end
    endtask

    task automatic test_min_neg();
        cur_l = 24'h800000; cur_r = 24'h800000;
        wait_frame(5);
        n_tests++; if (sample_l !== 24'h800000) begin n_fail++; $display("FAIL neg_l: got %h exp 800000", sample_l); end
        n_tests++; if (sample_r !== 24'h800000) begin n_fail++; $display("FAIL neg_r: got %h exp 800000", sample_r); end
        n_tests++; if (peak_hold !== 23'h7FFFFF) begin n_fail++; $display("FAIL neg_peak: got %h exp 7fffff", peak_hold); end
        n_tests++; if (led !== 10'h3FF) begin n_fail++; $display("FAIL neg_led: got %h exp 3ff", led); end
    endtask

    task automatic test_short_slot();
        int h, sv0, err0;
        l_len = 16; cur_l = 24'h111111; cur_r = 24'h222222;
        h = frame_cnt + 1;
        wait_frame(h);
        l_len = 32; cur_l = 24'h333333; cur_r = 24'h444444;
        sv0 = sv_cnt; err0 = err_cnt;
        wait_frame(h + 1);
        n_tests++; if (err_cnt !== err0 + 1) begin n_fail++; $display("FAIL short_err: got %0d exp %0d", err_cnt, err0 + 1); end
        n_tests++; if (sv_cnt !== sv0) begin n_fail++; $display("FAIL short_novalid: got %0d exp %0d", sv_cnt, sv0); end
        n_tests++; if (sample_l !== 24'h800000) begin n_fail++; $display("FAIL short_hold_l: got %h exp 800000", sample_l); end
        wait_frame(h + 2);
        n_tests++; if (sv_cnt !== sv0 + 1) begin n_fail++; $display("FAIL short_recover_valid: got %0d exp %0d", sv_cnt, sv0 + 1); end
        n_tests++; if (sample_l !== 24'h333333) begin n_fail++; $display("FAIL short_recover_l: got %h exp 333333", sample_l); end
        n_tests++; if (sample_r !== 24'h444444) begin n_fail++; $display("FAIL short_recover_r: got %h exp 444444", sample_r); end
        n_tests++; if (err_cnt !== err0 + 1) begin n_fail++; $display("FAIL short_err_once: got %0d exp %0d", err_cnt, err0 + 1); end
    endtask

    task automatic test_mid_reset();
        int f, sv0, i;
        cur_l = 24'h000055; cur_r = 24'hFFFFF0;
        i = 0;
        while (in_right == 0 && i < 4000) begin @(negedge clk); i++; end
        if (in_right == 0) begin
            n_tests++; n_fail++;
            $display("FAIL mid_reset_wait: in_right %0d required 1", in_right);
        end
        f = frame_cnt;
        repeat (200) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_tests++; if (sample_l !== '0) begin n_fail++; $display("FAIL mrst_l: got %h exp 0", sample_l); end
        n_tests++; if (sample_r !== '0) begin n_fail++; $display("FAIL mrst_r: got %h exp 0", sample_r); end
        n_tests++; if (peak_hold !== '0) begin n_fail++; $display("FAIL mrst_peak: got %h exp 0", peak_hold); end
        n_tests++; if (led !== '0) begin n_fail++; $display("FAIL mrst_led: got %h exp 0", led); end
        n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b exp 0", sample_valid); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL mrst_err: got %b exp 0", frame_err); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        sv0 = sv_cnt;
        wait_frame(f + 1);
        n_tests++; if (sv_cnt !== sv0) begin n_fail++; $display("FAIL mrst_novalid: got %0d exp %0d", sv_cnt, sv0); end
        n_tests++; if (sample_l !== '0) begin n_fail++; $display("FAIL mrst_l_kept: got %h exp 0", sample_l); end
        wait_frame(f + 2);
        n_tests++; if (sv_cnt !== sv0 + 1) begin n_fail++; $display("FAIL mrst_first_valid: got %0d exp %0d", sv_cnt, sv0 + 1); end
        n_tests++; if (sample_l !== 24'h000055) begin n_fail++; $display("FAIL mrst_l_new: got %h exp 000055", sample_l); end
        n_tests++; if (sample_r !== 24'hFFFFF0) begin n_fail++; $display("FAIL mrst_r_new: got %h exp fffff0", sample_r); end
        n_tests++; if (peak_hold !== 23'h000055) begin n_fail++; $display("FAIL mrst_peak_new: got %h exp 000055", peak_hold); end
        n_tests++; if (led !== 10'h000) begin n_fail++; $display("FAIL mrst_led_new: got %h exp 000", led); end
    endtask

    task automatic test_decay();
        int g;
        cur_l = 24'h010000; cur_r = 24'h000000;
        g = frame_cnt + 1;
        wait_frame(g);
        cur_l = 24'h000000;
        g_base = g;
        wait_frame(g + 1);
        n_tests++; if (peak_hold !== 23'h010000) begin n_fail++; $display("FAIL decay_load: got %h exp 010000", peak_hold); end
        n_tests++; if (led !== 10'h00F) begin n_fail++; $display("FAIL decay_led0: got %h exp 00f", led); end
        wait_frame(g + 4);
        n_tests++; if (peak_hold !== 23'h010000) begin n_fail++; $display("FAIL decay_hold3: got %h exp 010000", peak_hold); end
        wait_frame(g + 5);
        n_tests++; if (peak_hold !== 23'h00E000) begin n_fail++; $display("FAIL decay_step1: got %h exp 00e000", peak_hold); end
        n_tests++; if (led !== 10'h007) begin n_fail++; $display("FAIL decay_led1: got %h exp 007", led); end
        wait_frame(g + 9);
        n_tests++; if (peak_hold !== 23'h00C400) begin n_fail++; $display("FAIL decay_step2: got %h exp 00c400", peak_hold); end
        n_tests++; if (led !== 10'h007) begin n_fail++; $display("FAIL decay_led2: got %h exp 007", led); end
    endtask

    task automatic test_load_beats_decay();
        int g;
        g = g_base;
        wait_frame(g + 11);
        cur_l = 24'h020000;
        wait_frame(g + 12);
        cur_l = 24'h000000;
        wait_frame(g + 13);
        n_tests++; if (peak_hold !== 23'h020000) begin n_fail++; $display("FAIL tick_load: got %h exp 020000", peak_hold); end
        n_tests++; if (led !== 10'h01F) begin n_fail++; $display("FAIL tick_led: got %h exp 01f", led); end
        wait_frame(g + 16);
        n_tests++; if (peak_hold !== 23'h020000) begin n_fail++; $display("FAIL tick_cnt_cleared: got %h exp 020000", peak_hold); end
        wait_frame(g + 17);
        n_tests++; if (peak_hold !== 23'h01C000) begin n_fail++; $display("FAIL tick_next_decay: got %h exp 01c000", peak_hold); end
        n_tests++; if (led !== 10'h00F) begin n_fail++; $display("FAIL tick_next_led: got %h exp 00f", led); end
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_basic();
        test_min_neg();
        test_short_slot();
        test_mid_reset();
        test_decay();
        test_load_beats_decay();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
